// File: rtl/dcache_direct_mapped.sv
// Direct-mapped, write-back, write-allocate data cache between the MEM stage and a
// word-wide data memory; 4-word lines, misses stall the pipeline via cpu_busywait.
module dcache_direct_mapped #(
    parameter int NUM_LINES = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  cpu_read,
    input  logic [2:0]  cpu_write,
    input  logic [31:0] cpu_address,
    input  logic [31:0] cpu_writedata,
    output logic [31:0] cpu_readdata,
    output logic        cpu_busywait,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_writedata,
    input  logic [31:0] mem_readdata,
    input  logic        mem_busywait
);

    localparam int INDEX_BITS = $clog2(NUM_LINES);
    localparam int TAG_BITS   = 28 - INDEX_BITS;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITEBACK = 2'd1,
        S_FETCH_REQ = 2'd2,
        S_FETCH_CAP = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [1:0]              k_q, k_d;
    logic [TAG_BITS-1:0]     fill_tag_q, fill_tag_d;
    logic [INDEX_BITS-1:0]   fill_index_q, fill_index_d;

    logic [3:0][31:0]        data_q [NUM_LINES];
    logic [TAG_BITS-1:0]     tag_q  [NUM_LINES];
    logic [NUM_LINES-1:0]    valid_q;
    logic [NUM_LINES-1:0]    dirty_q;

    logic [TAG_BITS-1:0]     cpu_tag_s;
    logic [INDEX_BITS-1:0]   cpu_index_s;
    logic [1:0]              cpu_word_s;
    logic [1:0]              cpu_byte_s;
    logic                    is_load_s, is_store_s, access_s, hit_s;
    logic [31:0]             hit_word_s;
    logic                    miss_busy_s;
    logic                    mem_read_s, mem_write_s;
    logic [31:0]             mem_address_s, mem_writedata_s;

    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [2:0]  funct3,
                                                 input logic [1:0]  off);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (funct3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b010:  r = word;
            3'b100:  r = {24'h000000, b};
            3'b101:  r = {16'h0000, h};
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] old,
                                                input logic [31:0] wdata,
                                                input logic [1:0]  size,
                                                input logic [1:0]  off);
        logic [31:0] r;
        r = old;
        case (size)
            2'b00: r[{off, 3'b000} +: 8] = wdata[7:0];
            2'b01: begin
                if (off[1]) begin
                    r[31:16] = wdata[15:0];
                end else begin
                    r[15:0] = wdata[15:0];
                end
            end
            2'b10:   r = wdata;
            default: r = old;
        endcase
        return r;
    endfunction

    assign cpu_tag_s   = cpu_address[31:4+INDEX_BITS];
    assign cpu_index_s = cpu_address[3+INDEX_BITS:4];
    assign cpu_word_s  = cpu_address[3:2];
    assign cpu_byte_s  = cpu_address[1:0];

    // A request with both enables set is treated as no access at all.
    assign is_load_s  = cpu_read[3] & ~cpu_write[2];
    assign is_store_s = cpu_write[2] & ~cpu_read[3];
    assign access_s   = is_load_s | is_store_s;
    assign hit_s      = valid_q[cpu_index_s] && (tag_q[cpu_index_s] == cpu_tag_s);
    assign hit_word_s = data_q[cpu_index_s][cpu_word_s];

    // Next-state and memory-side request generation
    always_comb begin
        state_d         = state_q;
        k_d             = k_q;
        fill_tag_d      = fill_tag_q;
        fill_index_d    = fill_index_q;
        miss_busy_s     = 1'b0;
        mem_read_s      = 1'b0;
        mem_write_s     = 1'b0;
        mem_address_s   = 32'h0000_0000;
        mem_writedata_s = 32'h0000_0000;
        case (state_q)
            S_IDLE: begin
                if (access_s && !hit_s) begin
                    miss_busy_s  = 1'b1;
                    k_d          = 2'd0;
                    fill_tag_d   = cpu_tag_s;
                    fill_index_d = cpu_index_s;
                    if (valid_q[cpu_index_s] && dirty_q[cpu_index_s]) begin
                        state_d = S_WRITEBACK;
                    end else begin
                        state_d = S_FETCH_REQ;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WRITEBACK: begin
                mem_write_s     = 1'b1;
                mem_address_s   = {tag_q[fill_index_q], fill_index_q, k_q, 2'b00};
                mem_writedata_s = data_q[fill_index_q][k_q];
                if (!mem_busywait) begin
                    k_d = k_q + 2'd1;
                    if (k_q == 2'd3) begin
                        state_d = S_FETCH_REQ;
                    end else begin
                        state_d = S_WRITEBACK;
                    end
                end else begin
                    k_d = k_q;
                end
            end
            S_FETCH_REQ: begin
                mem_read_s    = 1'b1;
                mem_address_s = {fill_tag_q, fill_index_q, k_q, 2'b00};
                if (!mem_busywait) begin
                    state_d = S_FETCH_CAP;
                end else begin
                    state_d = S_FETCH_REQ;
                end
            end
            S_FETCH_CAP: begin
                mem_address_s = {fill_tag_q, fill_index_q, k_q, 2'b00};
                k_d           = k_q + 2'd1;
                if (k_q == 2'd3) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_FETCH_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
                k_d     = 2'd0;
            end
        endcase
    end

    // Outputs are forced quiet while reset is held low.
    assign mem_read      = reset & mem_read_s;
    assign mem_write     = reset & mem_write_s;
    assign mem_address   = reset ? mem_address_s : 32'h0000_0000;
    assign mem_writedata = reset ? mem_writedata_s : 32'h0000_0000;
    assign cpu_busywait  = reset & ((state_q != S_IDLE) | miss_busy_s);
    assign cpu_readdata  = (reset && (state_q == S_IDLE) && is_load_s && hit_s)
                         ? load_extract(hit_word_s, cpu_read[2:0], cpu_byte_s)
                         : 32'h0000_0000;

    // Controller state, word counter and latched miss address
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            k_q          <= 2'd0;
            fill_tag_q   <= '0;
            fill_index_q <= '0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            fill_tag_q   <= fill_tag_d;
            fill_index_q <= fill_index_d;
        end
    end

    // Line status bits
    always_ff @(posedge clock) begin
        if (!reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if ((state_q == S_FETCH_CAP) && (k_q == 2'd3)) begin
            valid_q[fill_index_q] <= 1'b1;
            dirty_q[fill_index_q] <= 1'b0;
        end else if ((state_q == S_IDLE) && is_store_s && hit_s) begin
            dirty_q[cpu_index_s] <= 1'b1;
        end else begin
            valid_q <= valid_q;
            dirty_q <= dirty_q;
        end
    end

    // Data and tag arrays: fill words from memory, merge store lanes on a hit
    always_ff @(posedge clock) begin
        if (reset) begin
            if (state_q == S_FETCH_CAP) begin
                data_q[fill_index_q][k_q] <= mem_readdata;
                if (k_q == 2'd3) begin
                    tag_q[fill_index_q] <= fill_tag_q;
                end
            end else if ((state_q == S_IDLE) && is_store_s && hit_s) begin
                data_q[cpu_index_s][cpu_word_s] <=
                    store_merge(hit_word_s, cpu_writedata, cpu_write[1:0], cpu_byte_s);
            end
        end
    end

endmodule

// File: tb/tb_dcache_direct_mapped.sv
// Scoreboard bench for dcache_direct_mapped: expected loads and memory transactions are
// queued by the stimulus and checked by an independent monitor.
module tb_dcache_direct_mapped;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  cpu_read = 4'b0000;
    logic [2:0]  cpu_write = 3'b000;
    logic [31:0] cpu_address = 32'h0;
    logic [31:0] cpu_writedata = 32'h0;
    logic [31:0] cpu_readdata;
    logic        cpu_busywait;
    logic        mem_read, mem_write;
    logic [31:0] mem_address, mem_writedata;
    logic [31:0] mem_readdata = 32'h0;
    logic        mem_busywait = 1'b0;

    typedef struct {
        bit          w;
        logic [31:0] a;
        logic [31:0] d;
    } mem_txn_t;

    logic [31:0] exp_load_q[$];
    mem_txn_t    exp_mem_q[$];
    logic [31:0] mem_model [256];
    bit          mem_init_done = 1'b0;
    int          n_checks = 0;
    int          n_err = 0;
    logic [31:0] stall_addr = 32'h0;
    int          stall_req = 0;
    int          stall_used = 0;

    always #5 clock = ~clock;

    dcache_direct_mapped #(.NUM_LINES(8)) dut (
        .clock(clock), .reset(reset),
        .cpu_read(cpu_read), .cpu_write(cpu_write),
        .cpu_address(cpu_address), .cpu_writedata(cpu_writedata),
        .cpu_readdata(cpu_readdata), .cpu_busywait(cpu_busywait),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_writedata(mem_writedata),
        .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
    );

    function automatic logic [31:0] init_word(input int i);
        logic [31:0] r;
        case (i)
            4:       r = 32'hA1B2C3D4;
            5:       r = 32'h00000001;
            6:       r = 32'h00000002;
            7:       r = 32'h00000003;
            default: r = 32'h5A000000 | i;
        endcase
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Word memory with registered read data
    always @(posedge clock) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 256; i++) mem_model[i] <= init_word(i);
            mem_init_done <= 1'b1;
        end else begin
            if (mem_read && !mem_busywait) mem_readdata <= mem_model[mem_address[9:2]];
            if (mem_write && !mem_busywait) mem_model[mem_address[9:2]] <= mem_writedata;
        end
    end

    // Injects memory wait states on a chosen read address
    always @(posedge clock) begin
        #2;
        if (stall_used < stall_req && mem_read && mem_address == stall_addr) begin
            mem_busywait = 1'b1;
            stall_used++;
        end else begin
            mem_busywait = 1'b0;
        end
    end

    // Monitor: completed loads and completed memory transfers
    always @(negedge clock) begin
        if (reset && cpu_read[3] && !cpu_write[2] && !cpu_busywait) begin
            if (exp_load_q.size() == 0) begin
                check("load_unexpected", cpu_readdata, 32'hxxxxxxxx);
            end else begin
                check("load_data", cpu_readdata, exp_load_q.pop_front());
            end
        end
        if (reset && (mem_read || mem_write) && !mem_busywait) begin
            if (exp_mem_q.size() == 0) begin
                check("mem_unexpected", mem_address, 32'hxxxxxxxx);
            end else begin
                mem_txn_t t;
                t = exp_mem_q.pop_front();
                check("mem_rw", {30'h0, mem_read, mem_write}, {30'h0, !t.w, t.w});
                check("mem_addr", mem_address, t.a);
                if (t.w) check("mem_wdata", mem_writedata, t.d);
            end
        end
    end

    task automatic exp_reads(input logic [31:0] base);
        for (int i = 0; i < 4; i++) exp_mem_q.push_back('{1'b0, base + 32'(4 * i), 32'h0});
    endtask

    task automatic do_access(input string name, input logic [3:0] rd, input logic [2:0] wr,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] exp_data, input int exp_busy);
        int  busy;
        bit  done;
        busy = 0;
        done = 1'b0;
        if (rd[3] && !wr[2]) exp_load_q.push_back(exp_data);
        cpu_read = rd;
        cpu_write = wr;
        cpu_address = addr;
        cpu_writedata = wdata;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clock);
            if (cpu_busywait) busy++;
            else done = 1'b1;
            @(posedge clock);
            #1;
        end
        cpu_read = 4'b0000;
        cpu_write = 3'b000;
        if (!done) check({name, "_timeout"}, 32'd0, 32'd1);
        check({name, "_busy_cycles"}, 32'(busy), 32'(exp_busy));
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        repeat (2) begin
            @(negedge clock);
            check("rst_busywait", {31'h0, cpu_busywait}, 32'h0);
            check("rst_mem_read", {31'h0, mem_read}, 32'h0);
            check("rst_mem_write", {31'h0, mem_write}, 32'h0);
            check("rst_readdata", cpu_readdata, 32'h0);
        end
        @(posedge clock);
        #1;
        reset = 1'b1;

        // Clean miss fill, then sub-word loads on the filled line
        exp_reads(32'h10);
        do_access("lw10_miss", 4'b1010, 3'b000, 32'h10, 32'h0, 32'hA1B2C3D4, 9);
        do_access("lb13", 4'b1000, 3'b000, 32'h13, 32'h0, 32'hFFFFFFA1, 0);
        do_access("lbu13", 4'b1100, 3'b000, 32'h13, 32'h0, 32'h000000A1, 0);
        do_access("lh12", 4'b1001, 3'b000, 32'h12, 32'h0, 32'hFFFFA1B2, 0);
        do_access("lhu10", 4'b1101, 3'b000, 32'h10, 32'h0, 32'h0000C3D4, 0);

        // Store hits, no memory traffic
        do_access("sb11", 4'b0000, 3'b100, 32'h11, 32'h00000055, 32'h0, 0);
        do_access("lw10_after_sb", 4'b1010, 3'b000, 32'h10, 32'h0, 32'hA1B255D4, 0);
        do_access("sh16", 4'b0000, 3'b101, 32'h16, 32'h0000BEEF, 32'h0, 0);
        do_access("lw14_after_sh", 4'b1010, 3'b000, 32'h14, 32'h0, 32'hBEEF0001, 0);

        // Dirty conflict miss: write-back of the old line precedes the fill
        exp_mem_q.push_back('{1'b1, 32'h10, 32'hA1B255D4});
        exp_mem_q.push_back('{1'b1, 32'h14, 32'hBEEF0001});
        exp_mem_q.push_back('{1'b1, 32'h18, 32'h00000002});
        exp_mem_q.push_back('{1'b1, 32'h1C, 32'h00000003});
        exp_reads(32'h90);
        do_access("lw90_dirty_miss", 4'b1010, 3'b000, 32'h90, 32'h0, 32'h5A000024, 13);

        // Memory wait states on fetch word 1
        stall_addr = 32'h24;
        stall_req = 3;
        exp_reads(32'h20);
        do_access("lw20_stalled", 4'b1010, 3'b000, 32'h20, 32'h0, 32'h5A000008, 12);

        // Reset in the middle of a fill (capture of word 2)
        exp_mem_q.push_back('{1'b0, 32'h30, 32'h0});
        exp_mem_q.push_back('{1'b0, 32'h34, 32'h0});
        exp_mem_q.push_back('{1'b0, 32'h38, 32'h0});
        cpu_read = 4'b1010;
        cpu_address = 32'h30;
        repeat (6) @(posedge clock);
        #1;
        reset = 1'b0;
        cpu_read = 4'b0000;
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(negedge clock);
        check("post_rst_mem_read", {31'h0, mem_read}, 32'h0);
        check("post_rst_busywait", {31'h0, cpu_busywait}, 32'h0);
        @(posedge clock);
        #1;
        exp_reads(32'h10);
        do_access("lw10_refetch", 4'b1010, 3'b000, 32'h10, 32'h0, 32'hA1B255D4, 9);
        exp_reads(32'h20);
        do_access("lw20_refetch", 4'b1010, 3'b000, 32'h20, 32'h0, 32'h5A000008, 9);

        // Both enables set: no access
        cpu_read = 4'b1010;
        cpu_write = 3'b110;
        cpu_address = 32'h10;
        cpu_writedata = 32'hFFFFFFFF;
        repeat (2) begin
            @(negedge clock);
            check("both_busywait", {31'h0, cpu_busywait}, 32'h0);
            check("both_mem_req", {30'h0, mem_read, mem_write}, 32'h0);
            @(posedge clock);
            #1;
        end
        cpu_read = 4'b0000;
        cpu_write = 3'b000;
        do_access("lw10_unchanged", 4'b1010, 3'b000, 32'h10, 32'h0, 32'hA1B255D4, 0);
        do_access("lb17", 4'b1000, 3'b000, 32'h17, 32'h0, 32'hFFFFFFBE, 0);

        repeat (3) @(posedge clock);
        check("load_queue_drained", 32'(exp_load_q.size()), 32'd0);
        check("mem_queue_drained", 32'(exp_mem_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
